nubus_bus_owner_seq: RTL

//  FPGA-side sequencer for the NuBus level-shifter/arbiter CPLD. Owns every CPLD control line:

---
 rtl/nubus_bus_owner_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/nubus_bus_owner_seq.sv
// Bus-ownership sequencer for the NuBus level-shifter/arbiter CPLD: fair arbitration, tenure handover,
// direction/OE control. Define NUBUS_LOCK_EN to let the master keep ownership across locked transactions.
module nubus_bus_owner_seq #(
    parameter int ARB_CYCLES    = 2,
    parameter int OE_DELAY      = 4,
    parameter int GRANT_TIMEOUT = 255,
    parameter int TIMEOUT_W     = 8
) (
    input  logic clk_n_3v3,
    input  logic reset_n_3v3,
    input  logic mst_req,
    input  logic mst_start_cyc,
    input  logic mst_done,
    input  logic mst_lock,
    output logic mst_grant,
    input  logic slv_ack_cyc,
    input  logic start_n_in,
    input  logic ack_n_in,
    input  logic rqst_n_in,
    input  logic grant,
    output logic arb,
    output logic rqst_o,
    output logic nubus_master_dir,
    output logic tmoen,
    output logic nubus_oe,
    output logic arb_timeout
);

    localparam int ARB_W = (ARB_CYCLES > 1) ? $clog2(ARB_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_RESET_HOLD, S_IDLE, S_FAIR_WAIT, S_ARB, S_LOST, S_WAIT_BUS, S_OWN, S_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [ARB_W-1:0]     arb_cnt_q, arb_cnt_d;
    logic                 fair_q, fair_d;
    logic                 busy_q, busy_d;
    logic                 arb_d, rqst_d, dir_d, tmoen_d, oe_d, grant_d, timeout_d;

`ifndef NUBUS_LOCK_EN
    logic unused_lock;
    assign unused_lock = mst_lock;
`endif

    // Ack closes a tenure even if a new START is seen in the same cycle.
    assign busy_d = !ack_n_in ? 1'b0 : (!start_n_in ? 1'b1 : busy_q);

    always_ff @(posedge clk_n_3v3) begin
        if (!reset_n_3v3) begin
            state_q     <= S_RESET_HOLD;
            cnt_q       <= '0;
            arb_cnt_q   <= '0;
            fair_q      <= 1'b0;
            busy_q      <= 1'b0;
            arb         <= 1'b0;
            rqst_o      <= 1'b0;
            nubus_master_dir <= 1'b0;
            tmoen       <= 1'b0;
            nubus_oe    <= 1'b1;
            mst_grant   <= 1'b0;
            arb_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arb_cnt_q   <= arb_cnt_d;
            fair_q      <= fair_d;
            busy_q      <= busy_d;
            arb         <= arb_d;
            rqst_o      <= rqst_d;
            nubus_master_dir <= dir_d;
            tmoen       <= tmoen_d;
            nubus_oe    <= oe_d;
            mst_grant   <= grant_d;
            arb_timeout <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        arb_cnt_d = '0;
        fair_d    = fair_q;
        case (state_q)
            S_RESET_HOLD: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (cnt_q == TIMEOUT_W'(OE_DELAY - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                if (mst_req) state_d = fair_q ? S_FAIR_WAIT : S_ARB;
            end
            S_FAIR_WAIT, S_ARB, S_LOST, S_WAIT_BUS: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                // Timeout outranks everything so the already-issued pulse always means an abort.
                if (cnt_q == TIMEOUT_W'(GRANT_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    fair_d  = 1'b1;
                    cnt_d   = '0;
                end else if (!mst_req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        S_FAIR_WAIT: if (rqst_n_in) begin
                            fair_d  = 1'b0;
                            state_d = S_ARB;
                        end
                        S_ARB: begin
                            if (arb_cnt_q == ARB_W'(ARB_CYCLES - 1))
                                state_d = grant ? S_WAIT_BUS : S_LOST;
                            else
                                arb_cnt_d = arb_cnt_q + ARB_W'(1);
                        end
                        S_LOST:     if (!ack_n_in) state_d = S_ARB;
                        S_WAIT_BUS: if (!busy_q) state_d = S_OWN;
                        default:    state_d = state_q;
                    endcase
                end
            end
            S_OWN: begin
`ifdef NUBUS_LOCK_EN
                if (mst_done && !mst_lock) state_d = S_RELEASE;
`else
                if (mst_done) state_d = S_RELEASE;
`endif
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                fair_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        arb_d     = (state_d == S_ARB) || (state_d == S_WAIT_BUS);
        rqst_d    = (state_d == S_ARB) || (state_d == S_WAIT_BUS) || (state_d == S_LOST);
        dir_d     = (state_d == S_OWN);
        grant_d   = (state_d == S_OWN);
        oe_d      = (state_d == S_RESET_HOLD);
        tmoen_d   = slv_ack_cyc;
        if (state_d == S_OWN)     tmoen_d = mst_start_cyc;
        if (state_d == S_RELEASE) tmoen_d = 1'b0;
        timeout_d = ((state_d == S_FAIR_WAIT) || (state_d == S_ARB) || (state_d == S_LOST) ||
                     (state_d == S_WAIT_BUS)) && (cnt_d == TIMEOUT_W'(GRANT_TIMEOUT - 1));
    end

endmodule
